bcd_counter4: RTL and testbench

//  4-digit BCD up/down counter that generates the digit values shown on the 4-digit

---
 rtl/bcd_counter4.sv | 144 ++++++++++++++
 tb/tb_bcd_counter4.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bcd_counter4.sv
// Purpose : 4-digit packed-BCD up/down counter that feeds the seven-segment display mux.
// Latency : digits and wrap update on the edge that samples the command (1 cycle); blank is combinational.
// Backpr. : none; one step per enable cycle, and clear/load take priority over enable.
//
// Ports:
//    clk, reset          - clock, synchronous active-high reset
//    enable, up          - count tick and direction (up ignored when enable is low)
//    clear, load         - synchronous clear to 0000 / load of load_value
//    load_value[15:0]    - packed BCD {d3,d2,d1,d0}; nibbles > 9 are clamped to 9
//    digit0..digit3      - registered BCD digits (digit0 = units)
//    blank[3:0]          - per-digit blank mask, decoded from the registered digits
//    wrap                - registered one-cycle pulse after a wrapping tick
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros (units never blanked).
// Without the macro, blank is tied to 4'b0000.

module bcd_counter4 #(
   parameter logic [15:0] MAX_BCD = 16'h9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        up,
   input  logic        clear,
   input  logic        load,
   input  logic [15:0] load_value,
   output logic [3:0]  digit0,
   output logic [3:0]  digit1,
   output logic [3:0]  digit2,
   output logic [3:0]  digit3,
   output logic [3:0]  blank,
   output logic        wrap
);

   logic [15:0] value_q, value_d;
   logic        wrap_q, wrap_d;
   logic [15:0] load_clamped;
   logic [15:0] value_inc;
   logic [15:0] value_dec;
   logic        inc_carry;
   logic        dec_borrow;

   // Clamp each load nibble to 9 so the register can never hold a non-BCD digit.
   always_comb begin
      load_clamped = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         if (load_value[4*i +: 4] > 4'd9) begin
            load_clamped[4*i +: 4] = 4'd9;
         end else begin
            load_clamped[4*i +: 4] = load_value[4*i +: 4];
         end
      end
   end

   // Ripple increment across all digits in one cycle (0999 -> 1000).
   always_comb begin
      value_inc = value_q;
      inc_carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (inc_carry) begin
            if (value_q[4*i +: 4] == 4'd9) begin
               value_inc[4*i +: 4] = 4'd0;
            end else begin
               value_inc[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
               inc_carry = 1'b0;
            end
         end
      end
   end

   // Ripple decrement with borrow (1000 -> 0999).
   always_comb begin
      value_dec  = value_q;
      dec_borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (dec_borrow) begin
            if (value_q[4*i +: 4] == 4'd0) begin
               value_dec[4*i +: 4] = 4'd9;
            end else begin
               value_dec[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
               dec_borrow = 1'b0;
            end
         end
      end
   end

   // Command priority: clear > load > enable. Wrap detection uses the whole packed
   // value; valid BCD orders the same as binary, so plain magnitude compares work.
   always_comb begin
      value_d = value_q;
      wrap_d  = 1'b0;
      if (clear) begin
         value_d = 16'h0000;
      end else if (load) begin
         value_d = (load_clamped > MAX_BCD) ? MAX_BCD : load_clamped;
      end else if (enable) begin
         if (up) begin
            if (value_q == MAX_BCD) begin
               value_d = 16'h0000;
               wrap_d  = 1'b1;
            end else begin
               value_d = value_inc;
            end
         end else begin
            if (value_q == 16'h0000) begin
               value_d = MAX_BCD;
               wrap_d  = 1'b1;
            end else begin
               value_d = value_dec;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= 16'h0000;
         wrap_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         wrap_q  <= wrap_d;
      end
   end

   assign digit0 = value_q[3:0];
   assign digit1 = value_q[7:4];
   assign digit2 = value_q[11:8];
   assign digit3 = value_q[15:12];
   assign wrap   = wrap_q;

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is blanked only if it and every more significant digit are zero.
   always_comb begin
      blank    = 4'b0000;
      blank[3] = (digit3 == 4'd0);
      blank[2] = blank[3] & (digit2 == 4'd0);
      blank[1] = blank[2] & (digit1 == 4'd0);
      blank[0] = 1'b0;
   end
`else
   assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_bcd_counter4.sv
// Bench for bcd_counter4: two instances share stimulus, one with the default top
// count (9999) and one with MAX_BCD = 0059. Expected results come from a vector
// table and a decimal reference model, queued when driven and popped after the edge.

module tb_bcd_counter4;

   logic        clk;
   logic        reset, enable, up, clear, load;
   logic [15:0] load_value;
   logic [3:0]  a_d0, a_d1, a_d2, a_d3, a_blank;
   logic [3:0]  b_d0, b_d1, b_d2, b_d3, b_blank;
   logic        a_wrap, b_wrap;

   bcd_counter4 dut_a (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
      .load_value(load_value), .digit0(a_d0), .digit1(a_d1), .digit2(a_d2), .digit3(a_d3),
      .blank(a_blank), .wrap(a_wrap)
   );

   bcd_counter4 #(.MAX_BCD(16'h0059)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
      .load_value(load_value), .digit0(b_d0), .digit1(b_d1), .digit2(b_d2), .digit3(b_d3),
      .blank(b_blank), .wrap(b_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r, c, l, e, u;
      logic [15:0] lv;
      logic [15:0] va;
      logic        wa;
      logic [15:0] vb;
      logic        wb;
   } vec_t;

   typedef struct {
      logic [15:0] va;
      logic        wa;
      logic [15:0] vb;
      logic        wb;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   function automatic logic [3:0] blank_model(input logic [15:0] v);
      logic b3, b2, b1;
      b3 = 1'b0; b2 = 1'b0; b1 = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      b3 = (v[15:12] == 4'd0);
      b2 = b3 && (v[11:8] == 4'd0);
      b1 = b2 && (v[7:4] == 4'd0);
`endif
      return {b3, b2, b1, 1'b0};
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'((n / 1000) % 10);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, c, l, e, u, input logic [15:0] lv,
                      input logic [15:0] va, input logic wa, input logic [15:0] vb, input logic wb);
      vec_t v;
      v.r = r; v.c = c; v.l = l; v.e = e; v.u = u; v.lv = lv;
      v.va = va; v.wa = wa; v.vb = vb; v.wb = wb;
      vecs.push_back(v);
   endtask

   // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
   task automatic step(input int idx, input logic r, c, l, e, u, input logic [15:0] lv, input exp_t ex);
      exp_t got;
      @(negedge clk);
      reset = r; clear = c; load = l; enable = e; up = u; load_value = lv;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check("a_value", idx, {a_d3, a_d2, a_d1, a_d0}, got.va);
      check("a_wrap",  idx, {15'd0, a_wrap}, {15'd0, got.wa});
      check("a_blank", idx, {12'd0, a_blank}, {12'd0, blank_model(got.va)});
      check("b_value", idx, {b_d3, b_d2, b_d1, b_d0}, got.vb);
      check("b_wrap",  idx, {15'd0, b_wrap}, {15'd0, got.wb});
      check("b_blank", idx, {12'd0, b_blank}, {12'd0, blank_model(got.vb)});
   endtask

   initial begin
      exp_t ex;
      int   na, nb;
      logic wa, wb;

      reset = 1'b1; clear = 1'b0; load = 1'b0; enable = 1'b0; up = 1'b0; load_value = 16'h0000;

      //  r  c  l  e  u  load_val   A val     wA   B val     wB
      add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 0, 0, 16'h0999, 16'h0999, 0, 16'h0059, 0);
      add(0, 0, 0, 1, 1, 16'h0000, 16'h1000, 0, 16'h0000, 1);
      add(0, 0, 0, 0, 0, 16'h0000, 16'h1000, 0, 16'h0000, 0);
      add(0, 0, 1, 0, 0, 16'h9999, 16'h9999, 0, 16'h0059, 0);
      add(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, 16'h0000, 1);
      add(0, 0, 0, 1, 0, 16'h0000, 16'h9999, 1, 16'h0059, 1);
      add(0, 0, 0, 0, 0, 16'h0000, 16'h9999, 0, 16'h0059, 0);
      add(0, 0, 0, 1, 0, 16'h0000, 16'h9998, 0, 16'h0058, 0);
      add(0, 0, 1, 1, 0, 16'h12AF, 16'h1299, 0, 16'h0059, 0);
      add(0, 0, 0, 1, 0, 16'h0000, 16'h1298, 0, 16'h0058, 0);
      add(0, 0, 1, 0, 0, 16'h0041, 16'h0041, 0, 16'h0041, 0);
      add(0, 1, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 0, 0, 16'h0042, 16'h0042, 0, 16'h0042, 0);
      add(0, 0, 0, 0, 1, 16'h0000, 16'h0042, 0, 16'h0042, 0);
      add(0, 0, 0, 1, 1, 16'h0000, 16'h0043, 0, 16'h0043, 0);
      add(0, 0, 1, 0, 0, 16'h0049, 16'h0049, 0, 16'h0049, 0);
      add(0, 0, 0, 1, 1, 16'h0000, 16'h0050, 0, 16'h0050, 0);
      add(0, 0, 1, 0, 0, 16'h0100, 16'h0100, 0, 16'h0059, 0);
      add(0, 0, 0, 1, 0, 16'h0000, 16'h0099, 0, 16'h0058, 0);
      add(0, 1, 1, 1, 1, 16'h5555, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 0, 1, 0, 16'h0000, 16'h9999, 1, 16'h0059, 1);
      add(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0);
      add(0, 0, 1, 0, 0, 16'hFFFF, 16'h9999, 0, 16'h0059, 0);
      add(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, 16'h0000, 1);
      add(0, 0, 1, 1, 0, 16'h9999, 16'h9999, 0, 16'h0059, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         ex.va = vecs[i].va; ex.wa = vecs[i].wa; ex.vb = vecs[i].vb; ex.wb = vecs[i].wb;
         step(i, vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].u, vecs[i].lv, ex);
      end

      // Long up run from zero against a decimal model: B wraps at 59 twice.
      ex.va = 16'h0000; ex.wa = 1'b0; ex.vb = 16'h0000; ex.wb = 1'b0;
      step(100, 0, 1, 0, 0, 0, 16'h0000, ex);
      na = 0; nb = 0;
      for (int i = 0; i < 130; i++) begin
         wa = (na == 9999); na = wa ? 0 : na + 1;
         wb = (nb == 59);   nb = wb ? 0 : nb + 1;
         ex.va = to_bcd(na); ex.wa = wa; ex.vb = to_bcd(nb); ex.wb = wb;
         step(200 + i, 0, 0, 0, 1, 1, 16'h0000, ex);
      end

      // Long down run: A crosses 0100 -> 0099 etc.; B wraps 0000 -> 0059.
      for (int i = 0; i < 80; i++) begin
         wa = (na == 0); na = wa ? 9999 : na - 1;
         wb = (nb == 0); nb = wb ? 59 : nb - 1;
         ex.va = to_bcd(na); ex.wa = wa; ex.vb = to_bcd(nb); ex.wb = wb;
         step(400 + i, 0, 0, 0, 1, 0, 16'h0000, ex);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
